// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, same-cycle ROM read, 2-entry
// {pc, instr} buffer towards decode, redirect handling and a sticky fault state.
module fetch_ctrl #(
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic        o_if_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_fault,
  output logic        o_dbg_state
);

  // Decode handshake: an entry transfers on a cycle where o_if_valid and
  // i_id_ready are both high; o_if_* hold steady while valid waits on ready.

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state_q;
  logic        fault_q;
  logic [31:0] pc_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_instr_q;
  logic [31:0] e1_pc_q, e1_instr_q;

  logic in_range, redirect_take, redirect_bad, range_fault, pop, push;

  always_comb begin
    in_range      = ({1'b0, pc_q} < PC_LIMIT);
    redirect_take = i_redirect && (state_q == S_RUN);
    redirect_bad  = |i_redirect_pc[1:0];
    range_fault   = (state_q == S_RUN) && !in_range;
    pop           = o_if_valid && i_id_ready;
    push          = (state_q == S_RUN) && i_en && in_range &&
                    ((count_q != 2'd2) || pop);
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_RUN;
      fault_q    <= 1'b0;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      e0_pc_q    <= 32'd0;
      e0_instr_q <= 32'd0;
      e1_pc_q    <= 32'd0;
      e1_instr_q <= 32'd0;
    end else if (redirect_take) begin
      // Redirect wins over push and pop; a misaligned target faults with PC held.
      count_q <= 2'd0;
      if (redirect_bad) begin
        state_q <= S_FAULT;
        fault_q <= 1'b1;
      end else begin
        pc_q <= i_redirect_pc;
      end
    end else begin
      if (range_fault) begin
        state_q <= S_FAULT;
        fault_q <= 1'b1;
      end
      if (push) pc_q <= pc_q + 32'd4;
      count_q <= count_d;
      if (pop) begin
        e0_pc_q    <= e1_pc_q;
        e0_instr_q <= e1_instr_q;
      end
      // The push lands in the first slot that is free after this cycle's pop.
      if (push) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          e0_pc_q    <= pc_q;
          e0_instr_q <= i_imem_instr;
        end else begin
          e1_pc_q    <= pc_q;
          e1_instr_q <= i_imem_instr;
        end
      end
    end
  end

  assign o_imem_addr = pc_q;
  assign o_if_valid  = (count_q != 2'd0);
  assign o_if_pc     = o_if_valid ? e0_pc_q : 32'd0;
  assign o_if_instr  = o_if_valid ? e0_instr_q : 32'd0;
  assign o_fault     = fault_q;
  assign o_dbg_state = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a default-sized instance for streaming,
// backpressure, redirect and fault cases, and a 4-word instance for range faults.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_en, a_redirect, a_ready, a_valid, a_fault, a_dbg;
  logic [31:0] a_redirect_pc, a_addr, a_instr_in, a_pc, a_instr;
  logic        b_rst_n, b_en, b_redirect, b_ready, b_valid, b_fault, b_dbg;
  logic [31:0] b_redirect_pc, b_addr, b_instr_in, b_pc, b_instr;

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  assign a_instr_in = rom(a_addr);
  assign b_instr_in = rom(b_addr);

  fetch_ctrl dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .i_redirect(a_redirect),
    .i_redirect_pc(a_redirect_pc), .o_imem_addr(a_addr), .i_imem_instr(a_instr_in),
    .o_if_valid(a_valid), .i_id_ready(a_ready), .o_if_pc(a_pc), .o_if_instr(a_instr),
    .o_fault(a_fault), .o_dbg_state(a_dbg)
  );

  fetch_ctrl #(.MEM_WORDS(4)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_redirect(b_redirect),
    .i_redirect_pc(b_redirect_pc), .o_imem_addr(b_addr), .i_imem_instr(b_instr_in),
    .o_if_valid(b_valid), .i_id_ready(b_ready), .o_if_pc(b_pc), .o_if_instr(b_instr),
    .o_fault(b_fault), .o_dbg_state(b_dbg)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted entry must match the next expected {pc, instr}.
  task automatic cycle();
    if (a_valid && a_ready) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $error("FAIL a_unexpected observed=%h expected=none", {a_pc, a_instr});
      end else chk("a_stream", {a_pc, a_instr}, exp_a.pop_front());
    end
    if (b_valid && b_ready) begin
      if (exp_b.size() == 0) begin
        total++;
        bad++;
        $error("FAIL b_unexpected observed=%h expected=none", {b_pc, b_instr});
      end else chk("b_stream", {b_pc, b_instr}, exp_b.pop_front());
    end
    tick();
  endtask

  task automatic push_a(input logic [31:0] pc);
    exp_a.push_back({pc, rom(pc)});
  endtask

  task automatic a_reset();
    a_rst_n = 1'b0; a_en = 1'b0; a_redirect = 1'b0; a_ready = 1'b0;
    a_redirect_pc = 32'd0;
    tick();
    tick();
    a_rst_n = 1'b1;
    exp_a.delete();
  endtask

  // Leaves dut_a faulted on range with 0x1F8 and 0x1FC still buffered.
  task automatic a_make_full_fault();
    a_reset();
    a_en = 1'b1;
    a_redirect = 1'b1; a_redirect_pc = 32'h1F8;
    tick();
    a_redirect = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b_rst_n = 1'b0; b_en = 1'b0; b_redirect = 1'b0; b_ready = 1'b0;
    b_redirect_pc = 32'd0;
    a_reset();
    a_rst_n = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_pc", 64'(a_pc), 64'd0);
    chk("rst_instr", 64'(a_instr), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_fault", 64'(a_fault), 64'd0);

    // Streaming: one instruction per cycle from reset release
    a_en = 1'b1; a_ready = 1'b1; a_rst_n = 1'b1;
    tick();
    chk("stream_first_valid", 64'(a_valid), 64'd1);
    n = $urandom_range(6, 10);
    for (int i = 0; i < n; i++) push_a(32'(i * 4));
    for (int i = 0; i < n; i++) begin
      chk("stream_valid", 64'(a_valid), 64'd1);
      cycle();
    end
    chk("stream_drained", 64'(exp_a.size()), 64'd0);

    // Backpressure: buffer fills at 2, PC stops at 8, head holds pc 0
    a_reset();
    a_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_addr", 64'(a_addr), 64'h8);
    chk("bp_head_pc", 64'(a_pc), 64'h0);
    chk("bp_valid", 64'(a_valid), 64'd1);
    for (int i = 0; i < 6; i++) push_a(32'(i * 4));
    a_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_release_valid", 64'(a_valid), 64'd1);
      cycle();
    end
    chk("bp_drained", 64'(exp_a.size()), 64'd0);

    // Redirect with two entries buffered
    a_reset();
    a_en = 1'b1;
    tick();
    tick();
    chk("rd_full_addr", 64'(a_addr), 64'h8);
    a_redirect = 1'b1; a_redirect_pc = 32'h40;
    tick();
    a_redirect = 1'b0;
    chk("rd_gap_valid", 64'(a_valid), 64'd0);
    chk("rd_addr", 64'(a_addr), 64'h40);
    tick();
    chk("rd_first_valid", 64'(a_valid), 64'd1);
    chk("rd_first", {a_pc, a_instr}, {32'h40, 32'h1000_0010});
    for (int i = 0; i < 4; i++) push_a(32'h40 + 32'(i * 4));
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Fetch disabled: PC holds, pops and redirects still work
    a_en = 1'b0;
    push_a(32'h50);
    cycle();
    chk("en0_addr", 64'(a_addr), 64'h54);
    chk("en0_valid", 64'(a_valid), 64'd0);
    tick();
    chk("en0_addr_hold", 64'(a_addr), 64'h54);
    a_redirect = 1'b1; a_redirect_pc = 32'h80;
    tick();
    a_redirect = 1'b0;
    chk("en0_redirect_addr", 64'(a_addr), 64'h80);
    tick();
    chk("en0_no_fetch", 64'(a_valid), 64'd0);

    // Misaligned redirect faults; later redirects are ignored
    a_reset();
    a_en = 1'b1; a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    a_redirect = 1'b1; a_redirect_pc = 32'h42;
    tick();
    a_redirect = 1'b0;
    chk("mis_fault", 64'(a_fault), 64'd1);
    chk("mis_valid", 64'(a_valid), 64'd0);
    chk("mis_addr", 64'(a_addr), 64'h4);
    for (int i = 0; i < 3; i++) tick();
    chk("mis_no_fetch", {31'd0, a_valid, a_addr}, {32'd0, 32'h4});
    a_redirect = 1'b1; a_redirect_pc = 32'h0;
    tick();
    a_redirect = 1'b0;
    chk("mis_ignore_redirect", {30'd0, a_fault, a_valid, a_addr}, {30'd0, 1'b1, 1'b0, 32'h4});

    // Range fault with two entries buffered, then reset mid-stream
    a_make_full_fault();
    chk("rng_fault", 64'(a_fault), 64'd1);
    chk("rng_head", {a_pc, a_instr}, {32'h1F8, rom(32'h1F8)});
    chk("rng_addr", 64'(a_addr), 64'h200);
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    chk("midrst_valid", 64'(a_valid), 64'd0);
    chk("midrst_fault", 64'(a_fault), 64'd0);
    chk("midrst_addr", 64'(a_addr), 64'h0);

    // Entries buffered before a range fault still drain
    a_make_full_fault();
    push_a(32'h1F8);
    push_a(32'h1FC);
    a_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("drain_done", 64'(exp_a.size()), 64'd0);
    chk("drain_valid", 64'(a_valid), 64'd0);
    chk("drain_fault", 64'(a_fault), 64'd1);

    // Four-word ROM: pcs 0..C delivered, pc 0x10 never presented
    b_en = 1'b1; b_ready = 1'b1; b_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_b.push_back({32'(i * 4), rom(32'(i * 4))});
    for (int i = 0; i < 10; i++) cycle();
    chk("small_fault", 64'(b_fault), 64'd1);
    chk("small_valid", 64'(b_valid), 64'd0);
    chk("small_all_seen", 64'(exp_b.size()), 64'd0);
    chk("small_addr", 64'(b_addr), 64'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
